// File: rtl/cmp_int_nbit_serial.sv
// Bit-serial n-bit integer comparator: accepts an operand pair, walks the bits
// LSB-first one per cycle, then presents registered lt/eq/gt flags.
module cmp_int_nbit_serial #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             lt_acc_reg, eq_acc_reg;
  logic             in_ready_reg, out_valid_reg;
  logic             lt_reg, eq_reg, gt_reg;

  logic a_bit, b_bit, last_bit;
  logic lt_acc_next, eq_acc_next;

  // A higher differing bit overwrites whatever a lower one decided; the sign
  // bit inverts the sense because a set MSB means a negative operand.
  always_comb begin
    a_bit       = a_sh_reg[0];
    b_bit       = b_sh_reg[0];
    last_bit    = (cnt_reg == CW'(WIDTH - 1));
    lt_acc_next = lt_acc_reg;
    eq_acc_next = eq_acc_reg;
    if (a_bit != b_bit) begin
      eq_acc_next = 1'b0;
      lt_acc_next = (SIGNED && last_bit) ? a_bit : b_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      cnt_reg       <= '0;
      lt_acc_reg    <= 1'b0;
      eq_acc_reg    <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      lt_reg        <= 1'b0;
      eq_reg        <= 1'b0;
      gt_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_sh_reg     <= A;
            b_sh_reg     <= B;
            cnt_reg      <= '0;
            lt_acc_reg   <= 1'b0;
            eq_acc_reg   <= 1'b1;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          lt_acc_reg <= lt_acc_next;
          eq_acc_reg <= eq_acc_next;
          if (last_bit) begin
            cnt_reg       <= '0;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            lt_reg        <= lt_acc_next;
            eq_reg        <= eq_acc_next;
            gt_reg        <= ~lt_acc_next & ~eq_acc_next;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign lt        = lt_reg;
  assign eq        = eq_reg;
  assign gt        = gt_reg;

endmodule

// File: tb/tb_cmp_int_nbit_serial.sv
// Bench for cmp_int_nbit_serial: one unsigned and one signed 8-bit instance,
// checked against an arithmetic compare model.
module tb_cmp_int_nbit_serial;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [1:0]     in_valid_v, in_ready_v, out_valid_v, out_ready_v;
  logic [1:0]     lt_v, eq_v, gt_v;
  logic [W-1:0]   a_v [2];
  logic [W-1:0]   b_v [2];

  int errors = 0;
  int checks = 0;

  // Index 0: unsigned instance, index 1: signed instance.
  cmp_int_nbit_serial #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .A(a_v[0]), .B(b_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .lt(lt_v[0]), .eq(eq_v[0]), .gt(gt_v[0])
  );

  cmp_int_nbit_serial #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .A(a_v[1]), .B(b_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .lt(lt_v[1]), .eq(eq_v[1]), .gt(gt_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer comparison, {lt, eq, gt}.
  function automatic logic [2:0] ref_cmp(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    if (sgn) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'({24'd0, a});
      ib = int'({24'd0, b});
    end
    return {ia < ib, ia == ib, ia > ib};
  endfunction

  function automatic logic [2:0] flags(input int s);
    return {lt_v[s], eq_v[s], gt_v[s]};
  endfunction

  task automatic run_one(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [2:0] exp;
    exp = ref_cmp(s == 1, a, b);
    @(negedge clk);
    check("in_ready_idle", in_ready_v[s], 1);
    in_valid_v[s] = 1'b1;
    a_v[s] = a;
    b_v[s] = b;
    @(negedge clk);
    in_valid_v[s] = 1'b0;
    n = 0;
    while (!out_valid_v[s] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, W);
    check("flags", flags(s), exp);
    $display("txn s=%0d A=%02h B=%02h lt=%0b eq=%0b gt=%0b", s, a, b, lt_v[s], eq_v[s], gt_v[s]);
    @(negedge clk);
    check("out_valid_after_hs", out_valid_v[s], 0);
    check("in_ready_after_hs", in_ready_v[s], 1);
  endtask

  task automatic b2b(input int s, input int n);
    logic [2:0] q[$];
    logic [2:0] exp, obs;
    logic [W-1:0] a, b;
    int pushed, got, cyc, last;
    pushed = 0; got = 0; cyc = 0; last = -1;
    while (got < n && cyc < 12 * n + 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid_v[s]) begin
        obs = flags(s);
        if (q.size() == 0) begin
          check("b2b_spurious", 1, 0);
        end else begin
          exp = q.pop_front();
          check("b2b_flags", obs, exp);
          check("b2b_onehot", $countones(obs), 1);
          $display("txn s=%0d b2b#%0d lt=%0b eq=%0b gt=%0b", s, got, obs[2], obs[1], obs[0]);
          got++;
        end
      end
      if (in_ready_v[s]) begin
        if (pushed < n) begin
          if (last >= 0) check("b2b_interval", cyc - last, W + 2);
          last = cyc;
          a = W'($urandom);
          b = ($urandom_range(3) == 0) ? a : W'($urandom);
          a_v[s] = a;
          b_v[s] = b;
          in_valid_v[s] = 1'b1;
          q.push_back(ref_cmp(s == 1, a, b));
          pushed++;
        end else begin
          in_valid_v[s] = 1'b0;
        end
      end
    end
    in_valid_v[s] = 1'b0;
    check("b2b_count", got, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] held;
    int seen;
    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = 2'b11;
    a_v[0] = '0; a_v[1] = '0;
    b_v[0] = '0; b_v[1] = '0;

    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready", in_ready_v[s], 1);
      check("rst_out_valid", out_valid_v[s], 0);
      check("rst_flags", flags(s), 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_one(1, 8'h80, 8'h7F);
    run_one(0, 8'h80, 8'h7F);
    run_one(1, 8'h5A, 8'h5A);
    run_one(1, 8'hFF, 8'h00);
    run_one(1, 8'h03, 8'h02);
    run_one(1, 8'hFE, 8'hFF);
    run_one(0, 8'hFE, 8'hFF);
    run_one(0, 8'h01, 8'h00);

    // Backpressure on the signed instance
    out_ready_v[1] = 1'b0;
    @(negedge clk);
    in_valid_v[1] = 1'b1;
    a_v[1] = 8'h11;
    b_v[1] = 8'hF0;
    @(negedge clk);
    a_v[1] = 8'h00;
    b_v[1] = 8'h00;
    seen = 0;
    while (!out_valid_v[1] && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("bp_latency", seen, W);
    held = flags(1);
    check("bp_flags", held, ref_cmp(1'b1, 8'h11, 8'hF0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid_v[1], 1);
      check("bp_hold", flags(1), held);
      check("bp_in_ready", in_ready_v[1], 0);
    end
    out_ready_v[1] = 1'b1;
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    check("bp_out_valid_done", out_valid_v[1], 0);
    check("bp_in_ready_done", in_ready_v[1], 1);
    $display("txn s=1 backpressure A=11 B=f0 lt=%0b eq=%0b gt=%0b", held[2], held[1], held[0]);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    in_valid_v[1] = 1'b1;
    a_v[1] = 8'h40;
    b_v[1] = 8'h41;
    @(posedge clk);
    #1 in_valid_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready_v[1], 1);
    check("midrst_out_valid", out_valid_v[1], 0);
    check("midrst_flags", flags(1), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid_v[1]) seen++;
    end
    check("midrst_no_result", seen, 0);
    $display("txn s=1 reset mid-run A=40 B=41 aborted");
    run_one(1, 8'h40, 8'h41);

    // Back-to-back random pairs on both instances
    fork
      b2b(0, 1000);
      b2b(1, 1000);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
